// File: rtl/dec_fl_release_sched_if.sv
// Release-scheduler bus: retirement/walk release lanes in, free-list write ports and status out.
// master = ROB/retire side that drives the lanes, slave = the scheduler.
interface dec_fl_release_sched_if #(
  parameter int PRF_CODE_WIDTH = 7
);
  logic                      i_cmt_vld_0;
  logic                      i_cmt_vld_1;
  logic                      i_cmt_vld_2;
  logic                      i_cmt_vld_3;
  logic [PRF_CODE_WIDTH-1:0] i_cmt_prf_code_0;
  logic [PRF_CODE_WIDTH-1:0] i_cmt_prf_code_1;
  logic [PRF_CODE_WIDTH-1:0] i_cmt_prf_code_2;
  logic [PRF_CODE_WIDTH-1:0] i_cmt_prf_code_3;
  logic                      i_walk_start;
  logic                      i_walk_vld_0;
  logic                      i_walk_vld_1;
  logic                      i_walk_vld_2;
  logic                      i_walk_vld_3;
  logic [PRF_CODE_WIDTH-1:0] i_walk_prf_code_0;
  logic [PRF_CODE_WIDTH-1:0] i_walk_prf_code_1;
  logic [PRF_CODE_WIDTH-1:0] i_walk_prf_code_2;
  logic [PRF_CODE_WIDTH-1:0] i_walk_prf_code_3;
  logic                      i_walk_done;
  logic                      o_walk_rdy;
  logic                      o_rename_hold;
  logic                      o_fl_wren_0;
  logic                      o_fl_wren_1;
  logic                      o_fl_wren_2;
  logic                      o_fl_wren_3;
  logic [PRF_CODE_WIDTH-1:0] o_fl_wr_prf_code_0;
  logic [PRF_CODE_WIDTH-1:0] o_fl_wr_prf_code_1;
  logic [PRF_CODE_WIDTH-1:0] o_fl_wr_prf_code_2;
  logic [PRF_CODE_WIDTH-1:0] o_fl_wr_prf_code_3;
  logic                      o_ovf;

  modport master (
    output i_cmt_vld_0, i_cmt_vld_1, i_cmt_vld_2, i_cmt_vld_3,
    output i_cmt_prf_code_0, i_cmt_prf_code_1, i_cmt_prf_code_2, i_cmt_prf_code_3,
    output i_walk_start, i_walk_done,
    output i_walk_vld_0, i_walk_vld_1, i_walk_vld_2, i_walk_vld_3,
    output i_walk_prf_code_0, i_walk_prf_code_1, i_walk_prf_code_2, i_walk_prf_code_3,
    input  o_walk_rdy, o_rename_hold, o_ovf,
    input  o_fl_wren_0, o_fl_wren_1, o_fl_wren_2, o_fl_wren_3,
    input  o_fl_wr_prf_code_0, o_fl_wr_prf_code_1, o_fl_wr_prf_code_2, o_fl_wr_prf_code_3
  );

  modport slave (
    input  i_cmt_vld_0, i_cmt_vld_1, i_cmt_vld_2, i_cmt_vld_3,
    input  i_cmt_prf_code_0, i_cmt_prf_code_1, i_cmt_prf_code_2, i_cmt_prf_code_3,
    input  i_walk_start, i_walk_done,
    input  i_walk_vld_0, i_walk_vld_1, i_walk_vld_2, i_walk_vld_3,
    input  i_walk_prf_code_0, i_walk_prf_code_1, i_walk_prf_code_2, i_walk_prf_code_3,
    output o_walk_rdy, o_rename_hold, o_ovf,
    output o_fl_wren_0, o_fl_wren_1, o_fl_wren_2, o_fl_wren_3,
    output o_fl_wr_prf_code_0, o_fl_wr_prf_code_1, o_fl_wr_prf_code_2, o_fl_wr_prf_code_3
  );
endinterface

// File: rtl/dec_fl_release_sched.sv
// Free-list release scheduler: merges retire and flush-walk releases into one FIFO drained 4/cycle.
// Optional DEC_FL_REL_SCHED_BYPASS_EN: commit lanes skip the queue while it is empty.
module dec_fl_release_sched #(
  parameter int DEPTH          = 16,
  parameter int PRF_CODE_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dec_fl_release_sched_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [PRF_CODE_WIDTH-1:0] code_t;
  typedef enum logic [1:0] {IDLE, WALK, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [AW-1:0] head, tail;
  logic          rename_hold;
  logic          ovf;
  code_t         mem [DEPTH];

  logic [3:0]    cmt_vld, walk_vld;
  code_t         cmt_code [4];
  code_t         walk_code [4];

  logic [CW-1:0] free_slots, deq_cnt, enq_cnt, enq_acc;
  logic          walk_rdy;
  logic          cmt_enq_en;
  logic [7:0]    lane_vld;
  code_t         lane_code [8];
  code_t         comp [8];
  logic [3:0]    fl_wren;
  code_t         fl_code [4];

  assign cmt_vld   = {bus.i_cmt_vld_3, bus.i_cmt_vld_2, bus.i_cmt_vld_1, bus.i_cmt_vld_0};
  assign walk_vld  = {bus.i_walk_vld_3, bus.i_walk_vld_2, bus.i_walk_vld_1, bus.i_walk_vld_0};
  assign cmt_code  = '{bus.i_cmt_prf_code_0, bus.i_cmt_prf_code_1,
                       bus.i_cmt_prf_code_2, bus.i_cmt_prf_code_3};
  assign walk_code = '{bus.i_walk_prf_code_0, bus.i_walk_prf_code_1,
                       bus.i_walk_prf_code_2, bus.i_walk_prf_code_3};

  assign free_slots = CW'(DEPTH) - count;
  // Walk beats carry up to 4 codes on top of 4 commit codes, so 8 free slots keep commits unthrottled.
  assign walk_rdy   = (state == WALK) && (free_slots >= CW'(8));
  assign deq_cnt    = (count > CW'(4)) ? CW'(4) : count;

`ifdef DEC_FL_REL_SCHED_BYPASS_EN
  assign cmt_enq_en = (count != '0);
`else
  assign cmt_enq_en = 1'b1;
`endif

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    enq_cnt = '0;
    for (int i = 0; i < 8; i++) comp[i] = '0;
    for (int i = 0; i < 4; i++) begin
      lane_vld[i]      = cmt_vld[i] & cmt_enq_en;
      lane_code[i]     = cmt_code[i];
      lane_vld[i + 4]  = walk_vld[i] & walk_rdy;
      lane_code[i + 4] = walk_code[i];
    end
    // Commit lanes first, then walk lanes, each in lane order.
    for (int i = 0; i < 8; i++) begin
      if (lane_vld[i]) begin
        comp[enq_cnt[2:0]] = lane_code[i];
        enq_cnt            = enq_cnt + CW'(1);
      end
    end
  end

  assign enq_acc   = (enq_cnt > free_slots) ? free_slots : enq_cnt;
  assign count_nxt = count + enq_acc - deq_cnt;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      fl_wren[n] = 1'b0;
      fl_code[n] = '0;
    end
    for (int n = 0; n < 4; n++) begin
      if (CW'(n) < deq_cnt) begin
        fl_wren[n] = 1'b1;
        fl_code[n] = mem[head + AW'(n)];
      end
    end
`ifdef DEC_FL_REL_SCHED_BYPASS_EN
    if (count == '0) begin : bypass_lanes
      logic [1:0] byp_idx;
      byp_idx = '0;
      for (int i = 0; i < 4; i++) begin
        if (cmt_vld[i]) begin
          fl_wren[byp_idx] = 1'b1;
          fl_code[byp_idx] = cmt_code[i];
          byp_idx          = byp_idx + 2'd1;
        end
      end
    end
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_walk_start)   state_nxt = WALK;
      WALK:    if (bus.i_walk_done)    state_nxt = DRAIN;
      DRAIN:   if (count_nxt == '0)    state_nxt = IDLE;
      default:                         state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      rename_hold <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      head        <= head + AW'(deq_cnt);
      tail        <= tail + AW'(enq_acc);
      rename_hold <= (state_nxt != IDLE);
      ovf         <= ovf | (enq_cnt > free_slots);
    end
  end

  // NOTE: queue storage is not reset; count gates every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (CW'(i) < enq_acc) mem[tail + AW'(i)] <= comp[i];
    end
  end

  assign bus.o_walk_rdy         = walk_rdy;
  assign bus.o_rename_hold      = rename_hold;
  assign bus.o_ovf              = ovf;
  assign bus.o_fl_wren_0        = fl_wren[0];
  assign bus.o_fl_wren_1        = fl_wren[1];
  assign bus.o_fl_wren_2        = fl_wren[2];
  assign bus.o_fl_wren_3        = fl_wren[3];
  assign bus.o_fl_wr_prf_code_0 = fl_code[0];
  assign bus.o_fl_wr_prf_code_1 = fl_code[1];
  assign bus.o_fl_wr_prf_code_2 = fl_code[2];
  assign bus.o_fl_wr_prf_code_3 = fl_code[3];

endmodule

// File: tb/tb_dec_fl_release_sched.sv
// Directed bench for dec_fl_release_sched: reset, commit path, walk back-pressure, recovery, wrap, mid-walk reset.
module tb_dec_fl_release_sched;

  localparam int PW = 7;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dec_fl_release_sched_if #(.PRF_CODE_WIDTH(PW)) bus ();

  dec_fl_release_sched #(.DEPTH(16), .PRF_CODE_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {4'b0, PW'(d), PW'(c), PW'(b), PW'(a)};
  endfunction

  function automatic logic [31:0] wren();
    return {28'b0, bus.o_fl_wren_3, bus.o_fl_wren_2, bus.o_fl_wren_1, bus.o_fl_wren_0};
  endfunction

  function automatic logic [31:0] codes();
    return {4'b0, bus.o_fl_wr_prf_code_3, bus.o_fl_wr_prf_code_2,
            bus.o_fl_wr_prf_code_1, bus.o_fl_wr_prf_code_0};
  endfunction

  task automatic set_cmt(input logic [3:0] v, input int c0, input int c1, input int c2, input int c3);
    {bus.i_cmt_vld_3, bus.i_cmt_vld_2, bus.i_cmt_vld_1, bus.i_cmt_vld_0} = v;
    bus.i_cmt_prf_code_0 = PW'(c0);
    bus.i_cmt_prf_code_1 = PW'(c1);
    bus.i_cmt_prf_code_2 = PW'(c2);
    bus.i_cmt_prf_code_3 = PW'(c3);
  endtask

  task automatic set_walk(input logic [3:0] v, input int c0, input int c1, input int c2, input int c3);
    {bus.i_walk_vld_3, bus.i_walk_vld_2, bus.i_walk_vld_1, bus.i_walk_vld_0} = v;
    bus.i_walk_prf_code_0 = PW'(c0);
    bus.i_walk_prf_code_1 = PW'(c1);
    bus.i_walk_prf_code_2 = PW'(c2);
    bus.i_walk_prf_code_3 = PW'(c3);
  endtask

  task automatic clear_in();
    set_cmt(4'b0, 0, 0, 0, 0);
    set_walk(4'b0, 0, 0, 0, 0);
    bus.i_walk_start = 1'b0;
    bus.i_walk_done  = 1'b0;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n = 1'b0;
    clear_in();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wren",  wren(),            32'h0);
    check("rst_codes", codes(),           32'h0);
    check("rst_rdy",   32'(bus.o_walk_rdy),    32'h0);
    check("rst_hold",  32'(bus.o_rename_hold), 32'h0);
    check("rst_ovf",   32'(bus.o_ovf),         32'h0);
    rst_n = 1'b1;

`ifdef DEC_FL_REL_SCHED_BYPASS_EN
    step(); set_cmt(4'b0001, 77, 0, 0, 0); probe();
    check("byp_wren",  wren(),  32'h1);
    check("byp_codes", codes(), pk(77, 0, 0, 0));
    step(); clear_in(); probe();
    check("byp_not_queued", wren(), 32'h0);
`else
    // Commit only: sparse lanes 0 and 2 compact onto write ports 0 and 1 one cycle later.
    step(); set_cmt(4'b0101, 5, 0, 9, 0); probe();
    check("cmt_same_cycle", wren(), 32'h0);
    step(); clear_in(); probe();
    check("cmt_wren",  wren(),  32'h3);
    check("cmt_codes", codes(), pk(5, 9, 0, 0));
    step(); probe();
    check("cmt_empty", wren(), 32'h0);
`endif

    // Walk lanes outside WALK are ignored.
    step(); set_walk(4'b0001, 99, 0, 0, 0); probe();
    check("idle_rdy", 32'(bus.o_walk_rdy), 32'h0);
    step(); clear_in(); probe();
    check("idle_walk_dropped", wren(), 32'h0);
    check("idle_hold", 32'(bus.o_rename_hold), 32'h0);

`ifndef DEC_FL_REL_SCHED_BYPASS_EN
    // Back-pressure: count 0 -> 8 -> 12; third beat's walk lanes are refused.
    step(); bus.i_walk_start = 1'b1; probe();
    check("bp_hold_start", 32'(bus.o_rename_hold), 32'h0);
    step(); clear_in(); set_cmt(4'hf, 10, 11, 12, 13); set_walk(4'hf, 20, 21, 22, 23); probe();
    check("bp_hold1", 32'(bus.o_rename_hold), 32'h1);
    check("bp_rdy1",  32'(bus.o_walk_rdy),    32'h1);
    step(); set_cmt(4'hf, 14, 15, 16, 17); set_walk(4'hf, 24, 25, 26, 27); probe();
    check("bp_rdy2",   32'(bus.o_walk_rdy), 32'h1);
    check("bp_wren2",  wren(),  32'hf);
    check("bp_codes2", codes(), pk(10, 11, 12, 13));
    step(); set_cmt(4'hf, 30, 31, 32, 33); set_walk(4'hf, 40, 41, 42, 43); probe();
    check("bp_rdy3",   32'(bus.o_walk_rdy), 32'h0);
    check("bp_codes3", codes(), pk(20, 21, 22, 23));
    step(); clear_in(); bus.i_walk_done = 1'b1; probe();
    check("bp_codes4", codes(), pk(14, 15, 16, 17));
    step(); bus.i_walk_done = 1'b0; probe();
    check("bp_codes5", codes(), pk(24, 25, 26, 27));
    step(); probe();
    check("bp_codes6", codes(), pk(30, 31, 32, 33));
    check("bp_hold6",  32'(bus.o_rename_hold), 32'h1);
    step(); probe();
    check("bp_drained", wren(), 32'h0);
    check("bp_hold_off", 32'(bus.o_rename_hold), 32'h0);
    check("bp_ovf", 32'(bus.o_ovf), 32'h0);
`endif

    // Recovery: 10 walk codes over 3 beats, done with the last beat.
    step(); bus.i_walk_start = 1'b1; probe();
    step(); clear_in(); set_walk(4'hf, 50, 51, 52, 53); probe();
    check("rec_hold1", 32'(bus.o_rename_hold), 32'h1);
    check("rec_rdy1",  32'(bus.o_walk_rdy),    32'h1);
    step(); set_walk(4'hf, 54, 55, 56, 57); probe();
    check("rec_codes2", codes(), pk(50, 51, 52, 53));
    check("rec_rdy2",   32'(bus.o_walk_rdy), 32'h1);
    step(); set_walk(4'b0011, 58, 59, 0, 0); bus.i_walk_done = 1'b1; probe();
    check("rec_codes3", codes(), pk(54, 55, 56, 57));
    step(); clear_in(); probe();
    check("rec_wren4",  wren(),  32'h3);
    check("rec_codes4", codes(), pk(58, 59, 0, 0));
    check("rec_rdy_drain", 32'(bus.o_walk_rdy),    32'h0);
    check("rec_hold4",     32'(bus.o_rename_hold), 32'h1);
    step(); probe();
    check("rec_hold_off", 32'(bus.o_rename_hold), 32'h0);
    check("rec_empty",    wren(), 32'h0);

`ifndef DEC_FL_REL_SCHED_BYPASS_EN
    // Wrap-around: codes 0..39 through lanes 1..3 (3 per beat), pointers cross 16 unaligned.
    for (int i = 0; i < 14; i++) begin
      step();
      if (i < 13) set_cmt(4'b1110, 0, 3 * i, 3 * i + 1, 3 * i + 2);
      else        set_cmt(4'b1000, 0, 0, 0, 39);
      probe();
      if (i > 0) begin
        check($sformatf("wrap_wren%0d", i),  wren(),  32'h7);
        check($sformatf("wrap_codes%0d", i), codes(), pk(3 * i - 3, 3 * i - 2, 3 * i - 1, 0));
      end
    end
    step(); clear_in(); probe();
    check("wrap_last_wren",  wren(),  32'h1);
    check("wrap_last_codes", codes(), pk(39, 0, 0, 0));
`endif

    // Reset mid-walk discards the queue.
    step(); bus.i_walk_start = 1'b1;
    step(); clear_in(); set_walk(4'hf, 60, 61, 62, 63);
    step(); clear_in(); probe();
    check("mid_wren_before", wren(), 32'hf);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_wren",  wren(),  32'h0);
    check("mid_rst_codes", codes(), 32'h0);
    check("mid_rst_hold",  32'(bus.o_rename_hold), 32'h0);
    check("mid_rst_rdy",   32'(bus.o_walk_rdy),    32'h0);
    step(); rst_n = 1'b1; probe();
    check("post_rst_wren", wren(), 32'h0);
    step(); probe();
    check("post_rst_empty", wren(), 32'h0);
    check("post_rst_ovf",   32'(bus.o_ovf), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dec_fl_release_sched.md
# dec_fl_release_sched

Release-port scheduler and flush-recovery sequencer in front of the decode-stage physical-register free list. It merges PRF codes freed by retirement and by the misprediction/flush ROB walk into one queue, and drains up to four codes per cycle onto the free list's four write ports. During a flush walk, and until every walked code has been returned, it holds rename so that no allocation sees a partially restored free list.

## Interface
- `DEPTH`, 16: release-queue entries; power of two, ≥ 8.
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `i_cmt_vld_0..3`  in  1 each  retirement release lane valid; lanes may be sparse.
- `i_cmt_prf_code_0..3`  in  `PRF_CODE_WIDTH` each  PRF code freed by retirement.
- `i_walk_start`  in  1  pulse; a flush walk begins.
- `i_walk_vld_0..3`  in  1 each  walk release lane valid.
- `i_walk_prf_code_0..3`  in  `PRF_CODE_WIDTH` each  speculatively allocated PRF code to return.
- `i_walk_done`  in  1  pulse; the last walk beat has been presented.
- `o_walk_rdy`  out  1  walk lanes accepted this cycle.
- `o_rename_hold`  out  1  rename must not request free-list entries.
- `o_fl_wren_0..3`  out  1 each  to the free list `i_fl_wren_*`.
- `o_fl_wr_prf_code_0..3`  out  `PRF_CODE_WIDTH` each  to the free list `i_fl_wr_prf_code_*`.
- `o_ovf`  out  1  sticky error flag: enqueue exceeded free slots.

## Operation
- **Queue**
  - Circular FIFO of `DEPTH` codes with head pointer, tail pointer and count; count width is log2(`DEPTH`)+1.
  - Pointers wrap modulo `DEPTH`.
- **Enqueue each cycle**
  - Compact the valid lanes in this order: commit lanes 0→3, then accepted walk lanes 0→3.
  - Lane order is preserved; up to 8 codes are written per cycle.
- **Dequeue each cycle**
  - k = min(count, 4).
  - `o_fl_wren_0..k-1` = 1; remaining wren = 0, with their codes driven 0.
  - Lane n carries entry head+n.
- **Count update**: count_nxt = count + enq − k.
- **Walk acceptance**
  - `o_walk_rdy` = (state == WALK) & (DEPTH − count ≥ 8).
  - Walk lanes are ignored whenever `o_walk_rdy` = 0.
  - Invariant: free slots ≥ 4 at every clock edge, so commit lanes are always accepted and never back-pressured.
  - If an enqueue would exceed free slots anyway, excess codes are dropped and `o_ovf` is set. `o_ovf` clears only on reset.
- **FSM**
  - IDLE → WALK on `i_walk_start`.
  - WALK → DRAIN on `i_walk_done`.
  - DRAIN → IDLE when count_nxt == 0.
  - `i_walk_start` is ignored outside IDLE; `i_walk_done` is ignored outside WALK.
  - `i_walk_start` and `i_walk_done` in the same IDLE cycle: go to WALK only; the done pulse is lost and is a protocol violation.
- **Hold**
  - `o_rename_hold` = (state != IDLE), a registered decode of the state.
  - Rename hold is independent of the free list's own `o_fl_stall`.

## Timing
- **Reset values**
  - State IDLE; count 0; head = tail = 0.
  - All `o_fl_wren_*` = 0; all `o_fl_wr_prf_code_*` = 0.
  - `o_walk_rdy` = 0, `o_rename_hold` = 0, `o_ovf` = 0.
- **Latency**
  - A code enqueued at edge N is driven on the write ports in cycle N+1 at earliest.
  - The free list absorbs it at edge N+2.
- **Walk timing**
  - `i_walk_start` at edge N: `o_rename_hold` = 1 from cycle N+1; `o_walk_rdy` can first be 1 in cycle N+1.
  - Last drain beat in cycle M: state is IDLE and `o_rename_hold` = 0 in cycle M+1.
- **Simultaneous events**: commit and walk in the same cycle are both enqueued, commit first.
- **Reset mid-walk**: queue contents are discarded; the ROB re-issues recovery after reset.

## Configuration
- **`DEC_FL_REL_SCHED_BYPASS_EN` defined**
  - When count == 0, compacted commit lanes drive `o_fl_wren_*` / `o_fl_wr_prf_code_*` combinationally in the same cycle and are not enqueued.
  - Walk lanes still enqueue.
- **Undefined**: all codes go through the queue with one-cycle latency.

## Test plan
- **Reset**
  - Stimulus: assert `rst_n` = 0 mid-cycle.
  - Response: all outputs 0 immediately; count 0 after release.
- **Commit only**
  - Stimulus: commit lanes 0 and 2 valid with codes 5 and 9.
  - Response: next cycle wren_0 = 1 code 5, wren_1 = 1 code 9, wren_2..3 = 0.
- **Walk back-pressure**
  - Stimulus: start, 4 commit + 4 walk codes per cycle for 3 cycles.
  - Response: count reaches 8 → `o_walk_rdy` = 0 when free < 8; no loss; `o_ovf` = 0.
- **Recovery sequence**
  - Stimulus: start, 10 walk codes over 3 beats, done.
  - Response: hold = 1 from start+1 until the cycle after the 10th code is written; state returns to IDLE.
- **Wrap-around**
  - Stimulus: stream 40 consecutive codes 0..39.
  - Response: emitted in order, with pointer wrap at 16.
- **Bypass (`DEC_FL_REL_SCHED_BYPASS_EN`)**
  - Stimulus: commit code 77 into an empty queue.
  - Response: wren_0 = 1 with code 77 in the same cycle.
